// File: rtl/zbin_pt_accumulator.sv
// Per-event (zbin x etabin) track-pT grid: accumulates through a one-stage add pipeline,
// then streams every bin out in zbin-major order, clearing each bin as its word is taken.
module zbin_pt_accumulator #(
  parameter int NZBINS   = 6,
  parameter int NETABINS = 24,
  parameter int PT_W     = 8,
  parameter int SUM_W    = 12
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        trk_valid,
  output logic                        trk_ready,
  input  logic                        trk_first,
  input  logic                        trk_last,
  input  logic [PT_W-1:0]             trk_pt,
  input  logic [$clog2(NETABINS)-1:0] trk_etabin,
  input  logic [3:0]                  zbin1,
  input  logic [3:0]                  zbin2,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [3:0]                  out_zbin,
  output logic [$clog2(NETABINS)-1:0] out_etabin,
  output logic [SUM_W-1:0]            out_sum,
  output logic                        out_last
);
  localparam int EW = $clog2(NETABINS);

  typedef enum logic [1:0] {ACCUM = 2'd0, DRAIN = 2'd1, READOUT = 2'd2} state_t;

  state_t            state_r, state_nxt_s;
  logic              trk_ready_r, trk_ready_nxt_s;
  logic              trk_xfer_s, out_xfer_s;
  logic              stage_valid_r;
  logic [PT_W-1:0]   stage_pt_r;
  logic [EW-1:0]     stage_eta_r;
  logic [3:0]        stage_z1_r, stage_z2_r;
  logic [SUM_W-1:0]  bins_r [NZBINS][NETABINS];
  logic [3:0]        rd_z_s;
  logic [EW-1:0]     rd_e_s;
  logic [SUM_W-1:0]  rd_sum_s;
  logic              out_valid_r, out_valid_nxt_s;
  logic [3:0]        out_zbin_r, out_zbin_nxt_s;
  logic [EW-1:0]     out_etabin_r, out_etabin_nxt_s;
  logic [SUM_W-1:0]  out_sum_r, out_sum_nxt_s;
  logic              out_last_r, out_last_nxt_s;

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                               input logic [PT_W-1:0] b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + {{(SUM_W + 1 - PT_W){1'b0}}, b};
    if (s[SUM_W]) return {SUM_W{1'b1}};
    else          return s[SUM_W-1:0];
  endfunction

  assign trk_xfer_s = trk_valid & trk_ready_r;
  assign out_xfer_s = out_valid_r & out_ready;
  assign trk_ready  = trk_ready_r;
  assign out_valid  = out_valid_r;
  assign out_zbin   = out_zbin_r;
  assign out_etabin = out_etabin_r;
  assign out_sum    = out_sum_r;
  assign out_last   = out_last_r;

  // State and track-ready registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ACCUM;
      trk_ready_r <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      trk_ready_r <= trk_ready_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ACCUM:   if (trk_xfer_s && trk_last) state_nxt_s = DRAIN;
               else                        state_nxt_s = ACCUM;
      DRAIN:   state_nxt_s = READOUT;
      READOUT: if (out_xfer_s && out_last_r) state_nxt_s = ACCUM;
               else                          state_nxt_s = READOUT;
      default: state_nxt_s = ACCUM;
    endcase
  end

  // FSM output: tracks are accepted only while the next state accumulates
  always_comb begin
    trk_ready_nxt_s = (state_nxt_s == ACCUM);
  end

  // Add-stage capture; trk_first carries no state because readout leaves the grid zeroed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid_r <= 1'b0;
      stage_pt_r    <= '0;
      stage_eta_r   <= '0;
      stage_z1_r    <= 4'd0;
      stage_z2_r    <= 4'd0;
    end else begin
      stage_valid_r <= trk_xfer_s;
      if (trk_xfer_s) begin
        stage_pt_r  <= trk_pt;
        stage_eta_r <= trk_etabin;
        stage_z1_r  <= zbin1;
        stage_z2_r  <= zbin2;
      end
    end
  end

  // Bin array: clear on word transfer, else saturating add; out-of-range codes match no bin
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int z = 0; z < NZBINS; z++)
        for (int e = 0; e < NETABINS; e++)
          bins_r[z][e] <= '0;
    end else begin
      for (int z = 0; z < NZBINS; z++) begin
        for (int e = 0; e < NETABINS; e++) begin
          if (out_xfer_s && out_zbin_r == 4'(z) && out_etabin_r == EW'(e))
            bins_r[z][e] <= '0;
          else if (stage_valid_r && stage_eta_r == EW'(e) &&
                   (stage_z1_r == 4'(z) || stage_z2_r == 4'(z)))
            bins_r[z][e] <= sat_add(bins_r[z][e], stage_pt_r);
          else
            bins_r[z][e] <= bins_r[z][e];
        end
      end
    end
  end

  // Address of the word to load next: (0,0) when idle, else successor of the held word
  always_comb begin
    if (!out_valid_r) begin
      rd_z_s = 4'd0;
      rd_e_s = '0;
    end else if (out_etabin_r == EW'(NETABINS - 1)) begin
      rd_z_s = out_zbin_r + 4'd1;
      rd_e_s = '0;
    end else begin
      rd_z_s = out_zbin_r;
      rd_e_s = out_etabin_r + EW'(1);
    end
  end

  // Read mux over the bin array
  always_comb begin
    rd_sum_s = '0;
    for (int z = 0; z < NZBINS; z++) begin
      for (int e = 0; e < NETABINS; e++) begin
        if (rd_z_s == 4'(z) && rd_e_s == EW'(e)) rd_sum_s = bins_r[z][e];
        else                                     rd_sum_s = rd_sum_s;
      end
    end
  end

  // Next output word: load on first readout cycle or on each transfer; hold while stalled
  always_comb begin
    out_valid_nxt_s  = out_valid_r;
    out_zbin_nxt_s   = out_zbin_r;
    out_etabin_nxt_s = out_etabin_r;
    out_sum_nxt_s    = out_sum_r;
    out_last_nxt_s   = out_last_r;
    if (state_r == READOUT && (!out_valid_r || out_ready)) begin
      if (out_valid_r && out_last_r) begin
        out_valid_nxt_s  = 1'b0;
        out_zbin_nxt_s   = 4'd0;
        out_etabin_nxt_s = '0;
        out_sum_nxt_s    = '0;
        out_last_nxt_s   = 1'b0;
      end else begin
        out_valid_nxt_s  = 1'b1;
        out_zbin_nxt_s   = rd_z_s;
        out_etabin_nxt_s = rd_e_s;
        out_sum_nxt_s    = rd_sum_s;
        out_last_nxt_s   = (rd_z_s == 4'(NZBINS - 1)) && (rd_e_s == EW'(NETABINS - 1));
      end
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
  end

  // Output word registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r  <= 1'b0;
      out_zbin_r   <= 4'd0;
      out_etabin_r <= '0;
      out_sum_r    <= '0;
      out_last_r   <= 1'b0;
    end else begin
      out_valid_r  <= out_valid_nxt_s;
      out_zbin_r   <= out_zbin_nxt_s;
      out_etabin_r <= out_etabin_nxt_s;
      out_sum_r    <= out_sum_nxt_s;
      out_last_r   <= out_last_nxt_s;
    end
  end

endmodule

// File: tb/tb_zbin_pt_accumulator.sv
// Self-checking bench for zbin_pt_accumulator: directed and random events compared
// against an event-level pT grid model with saturating sums.
module tb_zbin_pt_accumulator;
  localparam int NZ = 6;
  localparam int NE = 24;
  localparam int NWORDS = NZ * NE;
  localparam int SMAX = 4095;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       trk_valid = 1'b0;
  logic       trk_ready;
  logic       trk_first = 1'b0;
  logic       trk_last = 1'b0;
  logic [7:0] trk_pt = 8'd0;
  logic [4:0] trk_etabin = 5'd0;
  logic [3:0] zbin1 = 4'd0;
  logic [3:0] zbin2 = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_zbin;
  logic [4:0] out_etabin;
  logic [11:0] out_sum;
  logic       out_last;

  int tests_run = 0;
  int tests_failed = 0;
  int model [NZ][NE];

  zbin_pt_accumulator dut (
    .clk(clk), .reset_n(reset_n),
    .trk_valid(trk_valid), .trk_ready(trk_ready), .trk_first(trk_first), .trk_last(trk_last),
    .trk_pt(trk_pt), .trk_etabin(trk_etabin), .zbin1(zbin1), .zbin2(zbin2),
    .out_valid(out_valid), .out_ready(out_ready), .out_zbin(out_zbin),
    .out_etabin(out_etabin), .out_sum(out_sum), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int z = 0; z < NZ; z++)
      for (int e = 0; e < NE; e++)
        model[z][e] = 0;
  endfunction

  function automatic void model_add(input int z, input int e, input int pt);
    model[z][e] = (model[z][e] + pt > SMAX) ? SMAX : model[z][e] + pt;
  endfunction

  // Event-level rules: drop on bad eta, skip bad zbins, count equal zbins once
  function automatic void model_track(input int pt, input int e, input int z1, input int z2);
    if (e < NE) begin
      if (z1 < NZ) model_add(z1, e, pt);
      if (z2 < NZ && z2 != z1) model_add(z2, e, pt);
    end
  endfunction

  // Present a track and wait (bounded) for it to be accepted; caller is at posedge+1
  task automatic send_track(input int pt, input int e, input int z1, input int z2,
                            input bit first, input bit last);
    int n = 0;
    trk_valid = 1'b1; trk_pt = 8'(pt); trk_etabin = 5'(e);
    zbin1 = 4'(z1); zbin2 = 4'(z2); trk_first = first; trk_last = last;
    while (!trk_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!trk_ready) check("trk_accept_timeout", 32'(n), 32'd0);
    else begin
      @(posedge clk); #1;
      model_track(pt, e, z1, z2);
    end
    if (last) trk_valid = 1'b0;
  endtask

  // Consume words with a random ready duty; stop after stop_at words
  task automatic readout(input int duty, input int stop_at);
    int idx = 0;
    int cyc = 0;
    bit prev_stall = 1'b0;
    logic [31:0] prev = 32'd0;
    logic [31:0] cur;
    int exp;
    while (idx < stop_at && cyc < 3000) begin
      cur = {9'd0, out_valid, out_zbin, out_etabin, out_sum, out_last};
      if (prev_stall) check("stall_hold", cur, prev);
      if (out_valid) check("trk_ready_in_readout", 32'(trk_ready), 32'd0);
      out_ready = ($urandom_range(99) < duty);
      trk_valid = 1'($urandom_range(1));
      trk_last = 1'($urandom_range(1));
      trk_pt = 8'($urandom_range(255));
      trk_etabin = 5'($urandom_range(23));
      zbin1 = 4'($urandom_range(5));
      zbin2 = 4'($urandom_range(5));
      if (out_valid && out_ready) begin
        exp = ((idx / NE) << 18) | ((idx % NE) << 13) | (model[idx / NE][idx % NE] << 1)
              | ((idx == NWORDS - 1) ? 1 : 0);
        check($sformatf("word%0d", idx), cur[21:0], 32'(exp));
        idx++;
      end
      prev_stall = out_valid && !out_ready;
      prev = cur;
      @(posedge clk); #1; cyc++;
    end
    if (idx < stop_at) check("readout_timeout", 32'(idx), 32'(stop_at));
    trk_valid = 1'b0;
    out_ready = 1'b0;
    if (stop_at == NWORDS) begin
      check("valid_after_last", 32'(out_valid), 32'd0);
      model_clear();
    end
  endtask

  initial begin
    model_clear();
    #23;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_trk_ready", 32'(trk_ready), 32'd1);
    check("reset_out_word", {10'd0, out_zbin, out_etabin, out_sum, out_last}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: single track feeding two zbins
    send_track(10, 5, 2, 3, 1'b1, 1'b1);
    check("trk_ready_after_last", 32'(trk_ready), 32'd0);
    readout(100, NWORDS);

    // 2: equal zbins counted once, invalid zbin skipped
    send_track(7, 0, 4, 4, 1'b1, 1'b0);
    send_track(9, 3, 15, 1, 1'b0, 1'b1);
    readout(70, NWORDS);

    // 3: back-to-back same bin, 16 then 17 tracks (saturation)
    for (int i = 0; i < 16; i++) send_track(255, 0, 0, 0, i == 0, i == 15);
    check("sum16_model", 32'(model[0][0]), 32'h0FF0);
    readout(100, NWORDS);
    for (int i = 0; i < 17; i++) send_track(255, 0, 0, 0, i == 0, i == 16);
    check("sum17_model", 32'(model[0][0]), 32'd4095);
    readout(100, NWORDS);

    // 4: random events with invalid codes and random ready duty
    for (int ev = 0; ev < 4; ev++) begin
      int nt = $urandom_range(25, 1);
      for (int i = 0; i < nt; i++) begin
        int z1 = ($urandom_range(3) == 0) ? $urandom_range(15) : $urandom_range(5);
        int z2 = ($urandom_range(3) == 0) ? $urandom_range(15) : $urandom_range(5);
        int e  = ($urandom_range(7) == 0) ? $urandom_range(31) : $urandom_range(23);
        send_track($urandom_range(255), e, z1, z2, i == 0, i == nt - 1);
        if ($urandom_range(3) == 0 && i != nt - 1) begin
          trk_valid = 1'b0; @(posedge clk); #1;
        end
      end
      readout(35 + ev * 15, NWORDS);
    end

    // 5: event B right after A's readout, same bins
    for (int i = 0; i < 5; i++) send_track(200, 7, 1, 2, i == 0, i == 4);
    readout(100, NWORDS);
    send_track(3, 7, 1, 5, 1'b1, 1'b1);
    readout(80, NWORDS);

    // 6: reset mid-readout, then a fresh single-track event
    for (int i = 0; i < 6; i++) send_track(50 + i, i, i, 5 - i, i == 0, i == 5);
    readout(90, 50);
    reset_n = 1'b0;
    #1;
    check("midreset_valid", 32'(out_valid), 32'd0);
    check("midreset_word", {10'd0, out_zbin, out_etabin, out_sum, out_last}, 32'd0);
    check("midreset_trk_ready", 32'(trk_ready), 32'd1);
    #3;
    reset_n = 1'b1;
    model_clear();
    @(posedge clk); #1;
    send_track(21, 23, 5, 0, 1'b1, 1'b1);
    readout(100, NWORDS);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
